ntsc_joystick: RTL and testbench

Conditions the four active-low direction buttons and maintains the ball position consumed by the NTSC scan generator. It sits directly upstream of the video stage. Per button: two-flop synchroniser and counter-based debouncer. Once per video frame it steps a clamped X/Y position, which drives the scan generator's ball coordinate inputs.

---
 rtl/ntsc_joystick.sv | 162 ++++++++++++++++
 tb/tb_ntsc_joystick.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntsc_joystick.sv
// Button conditioning (2-flop sync + debounce) and per-frame clamped ball position for the NTSC scan generator.
// Define NTSC_JOY_ACCEL_EN to build the per-axis hold counters that double the step after 31 held frames.
module ntsc_joystick #(
  parameter int DEBOUNCE_CYCLES = 18000,
  parameter int CNT_WIDTH       = 15,
  parameter int X_MIN           = 10,
  parameter int X_MAX           = 56,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 30,
  parameter int X_RESET         = 33,
  parameter int Y_RESET         = 15
) (
  input  logic       ntscClock,
  input  logic       reset,
  input  logic       left_n,
  input  logic       right_n,
  input  logic       up_n,
  input  logic       down_n,
  input  logic       frameTick,
  output logic [5:0] ballX,
  output logic [5:0] ballY,
  output logic [3:0] pressed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] X_LO = 7'(X_MIN);
  localparam logic [6:0] X_HI = 7'(X_MAX);
  localparam logic [6:0] Y_LO = 7'(Y_MIN);
  localparam logic [6:0] Y_HI = 7'(Y_MAX);

  logic [3:0]           raw_n;
  logic [3:0]           sync1_q, sync1_d;
  logic [3:0]           sync2_q, sync2_d;
  logic [3:0]           sample;
  logic [3:0]           pressed_q, pressed_d;
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];
  logic [5:0]           ballx_q, ballx_d;
  logic [5:0]           bally_q, bally_d;
  logic [1:0]           step_x, step_y;

  // Bit order matches the pressed output: {up, down, left, right}.
  assign raw_n  = {up_n, down_n, left_n, right_n};
  assign sample = ~sync2_q;

  // Out-of-range positions snap to the nearest bound; sums are 7 bits so nothing wraps.
  function automatic logic [5:0] step_axis(input logic [5:0] pos, input logic inc,
                                           input logic dec, input logic [1:0] step,
                                           input logic [6:0] lo, input logic [6:0] hi);
    logic [6:0] p;
    logic [6:0] sum;
    logic [6:0] diff;
    p    = {1'b0, pos};
    sum  = p + {5'b0, step};
    diff = p - {5'b0, step};
    if (p < lo) return lo[5:0];
    if (p > hi) return hi[5:0];
    if (inc && !dec) return (sum > hi) ? hi[5:0] : sum[5:0];
    if (dec && !inc) return (p < lo + {5'b0, step}) ? lo[5:0] : diff[5:0];
    return pos;
  endfunction

  always_comb begin
    sync1_d   = raw_n;
    sync2_d   = sync1_q;
    pressed_d = pressed_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample[i] == pressed_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        pressed_d[i] = sample[i];
        cnt_d[i]     = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef NTSC_JOY_ACCEL_EN
  logic [4:0] holdx_q, holdx_d;
  logic [4:0] holdy_q, holdy_d;
  logic       dirx_q, dirx_d;
  logic       diry_q, diry_d;

  // dir records the direction last counted (1 = increasing coordinate) so a reversal restarts the count.
  always_comb begin
    holdx_d = holdx_q;
    dirx_d  = dirx_q;
    if (!(pressed_q[0] ^ pressed_q[1])) begin
      holdx_d = '0;
    end else if (frameTick) begin
      dirx_d = pressed_q[0];
      if (holdx_q != 5'd0 && dirx_q != pressed_q[0]) holdx_d = '0;
      else if (holdx_q != 5'd31)                     holdx_d = holdx_q + 5'd1;
    end

    holdy_d = holdy_q;
    diry_d  = diry_q;
    if (!(pressed_q[2] ^ pressed_q[3])) begin
      holdy_d = '0;
    end else if (frameTick) begin
      diry_d = pressed_q[2];
      if (holdy_q != 5'd0 && diry_q != pressed_q[2]) holdy_d = '0;
      else if (holdy_q != 5'd31)                     holdy_d = holdy_q + 5'd1;
    end
  end

  assign step_x = (holdx_q == 5'd31) ? 2'd2 : 2'd1;
  assign step_y = (holdy_q == 5'd31) ? 2'd2 : 2'd1;

  always_ff @(posedge ntscClock or posedge reset) begin
    if (reset) begin
      holdx_q <= '0;
      holdy_q <= '0;
      dirx_q  <= 1'b0;
      diry_q  <= 1'b0;
    end else begin
      holdx_q <= holdx_d;
      holdy_q <= holdy_d;
      dirx_q  <= dirx_d;
      diry_q  <= diry_d;
    end
  end
`else
  assign step_x = 2'd1;
  assign step_y = 2'd1;
`endif

  // Movement reads the registered pressed value, so a same-edge debounce update lands next frame.
  always_comb begin
    ballx_d = ballx_q;
    bally_d = bally_q;
    if (frameTick) begin
      ballx_d = step_axis(ballx_q, pressed_q[0], pressed_q[1], step_x, X_LO, X_HI);
      bally_d = step_axis(bally_q, pressed_q[2], pressed_q[3], step_y, Y_LO, Y_HI);
    end
  end

  always_ff @(posedge ntscClock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      pressed_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      ballx_q   <= 6'(X_RESET);
      bally_q   <= 6'(Y_RESET);
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      ballx_q   <= ballx_d;
      bally_q   <= bally_d;
    end
  end

  assign ballX   = ballx_q;
  assign ballY   = bally_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_ntsc_joystick.sv
// Scoreboard bench for ntsc_joystick with DEBOUNCE_CYCLES = 4; frame results are queued at stimulus time.
// Accelerated-step expectations follow NTSC_JOY_ACCEL_EN when it is defined for the build.
module tb_ntsc_joystick;

  logic       ntscClock = 1'b0;
  logic       reset     = 1'b0;
  logic       left_n    = 1'b1;
  logic       right_n   = 1'b1;
  logic       up_n      = 1'b1;
  logic       down_n    = 1'b1;
  logic       frameTick = 1'b0;
  logic [5:0] ballX;
  logic [5:0] ballY;
  logic [3:0] pressed;
  bit         clk_en    = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state: position, hold counters, hold direction, expected pressed.
  int         mx  = 33;
  int         my  = 15;
  int         mhx = 0;
  int         mhy = 0;
  bit         mdx = 1'b0;
  bit         mdy = 1'b0;
  logic [3:0] mp  = 4'b0000;
  int         x_at31;
  int         x_at32;
  int         max_y;

  ntsc_joystick #(.DEBOUNCE_CYCLES(4)) dut (
    .ntscClock (ntscClock),
    .reset     (reset),
    .left_n    (left_n),
    .right_n   (right_n),
    .up_n      (up_n),
    .down_n    (down_n),
    .frameTick (frameTick),
    .ballX     (ballX),
    .ballY     (ballY),
    .pressed   (pressed)
  );

  initial forever begin
    #5;
    if (clk_en) ntscClock = ~ntscClock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int axis(input int pos, input bit inc, input bit dec,
                              input int st, input int lo, input int hi);
    if (pos < lo) return lo;
    if (pos > hi) return hi;
    if (inc && !dec) return (pos + st > hi) ? hi : pos + st;
    if (dec && !inc) return (pos - st < lo) ? lo : pos - st;
    return pos;
  endfunction

  task automatic hold_upd(input bit inc, input bit dec, inout int h, inout bit d);
    if (inc ^ dec) begin
      if (h != 0 && d != inc) h = 0;
      else if (h < 31)        h = h + 1;
      d = inc;
    end else begin
      h = 0;
    end
  endtask

  task automatic model_tick();
    int stx;
    int sty;
    stx = 1;
    sty = 1;
`ifdef NTSC_JOY_ACCEL_EN
    if (mhx == 31) stx = 2;
    if (mhy == 31) sty = 2;
    hold_upd(mp[0], mp[1], mhx, mdx);
    hold_upd(mp[2], mp[3], mhy, mdy);
`endif
    mx = axis(mx, mp[0], mp[1], stx, 10, 56);
    my = axis(my, mp[2], mp[3], sty, 0, 30);
  endtask

  // Drives n consecutive frameTick cycles; each edge's result is queued then compared after that edge.
  task automatic tick_burst(input int n);
    exp_t e;
    @(negedge ntscClock);
    frameTick = 1'b1;
    for (int k = 0; k < n; k++) begin
      model_tick();
      e.x = 6'(mx);
      e.y = 6'(my);
      sb_q.push_back(e);
      @(negedge ntscClock);
      if (k == n - 1) frameTick = 1'b0;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL frame_pos: scoreboard empty, got x=%0d y=%0d", ballX, ballY);
      end else begin
        e = sb_q.pop_front();
        if ({ballX, ballY} !== {e.x, e.y}) begin
          errors++;
          $display("FAIL frame_pos: got x=%0d y=%0d expected x=%0d y=%0d", ballX, ballY, e.x, e.y);
        end
      end
    end
  endtask

  task automatic set_buttons(input bit l, input bit r, input bit u, input bit d);
    @(negedge ntscClock);
    left_n  = ~l;
    right_n = ~r;
    up_n    = ~u;
    down_n  = ~d;
    repeat (8) @(negedge ntscClock);
    mp = {u, d, l, r};
    if (!(r ^ l)) mhx = 0;
    if (!(u ^ d)) mhy = 0;
    checks++;
    if (pressed !== mp) begin
      errors++;
      $display("FAIL pressed_settle: got %b expected %b", pressed, mp);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ballX !== 6'd33) begin errors++; $display("FAIL reset_x: got %0d expected 33", ballX); end
    checks++;
    if (ballY !== 6'd15) begin errors++; $display("FAIL reset_y: got %0d expected 15", ballY); end
    checks++;
    if (pressed !== 4'b0000) begin errors++; $display("FAIL reset_pressed: got %b expected 0000", pressed); end
    clk_en = 1'b1;
    repeat (3) @(negedge ntscClock);
    reset = 1'b0;
    tick_burst(10);
  endtask

  task automatic test_glitch();
    @(negedge ntscClock);
    right_n = 1'b0;
    repeat (3) @(negedge ntscClock);
    right_n = 1'b1;
    repeat (6) @(negedge ntscClock);
    checks++;
    if (pressed !== 4'b0000) begin errors++; $display("FAIL glitch_pressed: got %b expected 0000", pressed); end
    tick_burst(1);
    checks++;
    if (ballX !== 6'd33) begin errors++; $display("FAIL glitch_x: got %0d expected 33", ballX); end
    // Held press: pressed[0] must rise on exactly the sixth edge.
    @(negedge ntscClock);
    right_n = 1'b0;
    repeat (5) @(negedge ntscClock);
    checks++;
    if (pressed !== 4'b0000) begin errors++; $display("FAIL debounce_early: got %b expected 0000", pressed); end
    @(negedge ntscClock);
    checks++;
    if (pressed !== 4'b0001) begin errors++; $display("FAIL debounce_edge: got %b expected 0001", pressed); end
    mp = 4'b0001;
    set_buttons(0, 0, 0, 0);
  endtask

  task automatic test_clamp();
    set_buttons(0, 1, 1, 0);
    repeat (40) tick_burst(1);
    checks++;
    if (ballX !== 6'd56) begin errors++; $display("FAIL clamp_x: got %0d expected 56", ballX); end
    checks++;
    if (ballY !== 6'd0) begin errors++; $display("FAIL clamp_y: got %0d expected 0", ballY); end
    tick_burst(3);
    checks++;
    if ({ballX, ballY} !== {6'd56, 6'd0}) begin
      errors++;
      $display("FAIL clamp_hold: got x=%0d y=%0d expected x=56 y=0", ballX, ballY);
    end
    set_buttons(0, 0, 0, 0);
  endtask

  task automatic test_reset_midrun();
    @(negedge ntscClock);
    left_n = 1'b0;
    repeat (2) @(negedge ntscClock);
    reset = 1'b1;
    #1;
    checks++;
    if ({ballX, ballY, pressed} !== {6'd33, 6'd15, 4'b0000}) begin
      errors++;
      $display("FAIL reset_midrun: got x=%0d y=%0d p=%b expected x=33 y=15 p=0000", ballX, ballY, pressed);
    end
    @(negedge ntscClock);
    left_n = 1'b1;
    @(negedge ntscClock);
    reset = 1'b0;
    mx = 33; my = 15; mhx = 0; mhy = 0; mdx = 1'b0; mdy = 1'b0; mp = 4'b0000;
    repeat (8) @(negedge ntscClock);
    checks++;
    if (pressed !== 4'b0000) begin errors++; $display("FAIL reset_debounce: got %b expected 0000", pressed); end
  endtask

  task automatic test_opposing();
    set_buttons(1, 1, 0, 0);
    tick_burst(5);
    checks++;
    if (ballX !== 6'd33) begin errors++; $display("FAIL opposing_x: got %0d expected 33", ballX); end
    set_buttons(0, 0, 1, 1);
    tick_burst(5);
    checks++;
    if (ballY !== 6'd15) begin errors++; $display("FAIL opposing_y: got %0d expected 15", ballY); end
    set_buttons(0, 0, 0, 0);
  endtask

  task automatic test_race();
    @(negedge ntscClock);
    left_n = 1'b0;
    repeat (4) @(negedge ntscClock);
    // This tick's edge is the one where pressed[1] rises; the model still holds the old pressed.
    tick_burst(1);
    checks++;
    if (ballX !== 6'd33) begin errors++; $display("FAIL race_same_edge: got %0d expected 33", ballX); end
    mp = 4'b0010;
    checks++;
    if (pressed !== 4'b0010) begin errors++; $display("FAIL race_pressed: got %b expected 0010", pressed); end
    tick_burst(1);
    checks++;
    if (ballX !== 6'd32) begin errors++; $display("FAIL race_next: got %0d expected 32", ballX); end
  endtask

  task automatic test_back_to_back();
    tick_burst(5);
    checks++;
    if (ballX !== 6'd27) begin errors++; $display("FAIL back_to_back: got %0d expected 27", ballX); end
  endtask

  task automatic test_accel();
    set_buttons(1, 0, 1, 0);
    tick_burst(30);
    set_buttons(0, 0, 0, 0);
    set_buttons(0, 1, 0, 1);
    max_y  = 0;
    x_at31 = -1;
    x_at32 = -1;
    for (int t = 1; t <= 40; t++) begin
      tick_burst(1);
      if (t == 31) x_at31 = int'(ballX);
      if (t == 32) x_at32 = int'(ballX);
      if (int'(ballY) > max_y) max_y = int'(ballY);
    end
    checks++;
    if (x_at31 != 41) begin errors++; $display("FAIL accel_tick31: got %0d expected 41", x_at31); end
`ifdef NTSC_JOY_ACCEL_EN
    checks++;
    if (x_at32 != 43) begin errors++; $display("FAIL accel_tick32: got %0d expected 43", x_at32); end
    checks++;
    if (ballX !== 6'd56) begin errors++; $display("FAIL accel_final_x: got %0d expected 56", ballX); end
`else
    checks++;
    if (x_at32 != 42) begin errors++; $display("FAIL accel_tick32: got %0d expected 42", x_at32); end
    checks++;
    if (ballX !== 6'd50) begin errors++; $display("FAIL accel_final_x: got %0d expected 50", ballX); end
`endif
    checks++;
    if (ballY !== 6'd30) begin errors++; $display("FAIL accel_final_y: got %0d expected 30", ballY); end
    checks++;
    if (max_y != 30) begin errors++; $display("FAIL accel_max_y: got %0d expected 30", max_y); end
    set_buttons(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clamp();
    test_reset_midrun();
    test_opposing();
    test_race();
    test_back_to_back();
    test_accel();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
